ir_cmd_ctrl: RTL
================

Name: ir_cmd_ctrl

Overview:
- Command-control stage directly downstream of the NEC infrared receiver (infrared_rcv).
- Consumes its data/data_valid/repeat_en outputs, filters frames by device address, and maps NEC command bytes to TV actions: power, channel ±, volume ±.
- Holds the resulting TV state registers that drive the display/actuator logic.
- Handles NEC repeat codes (held button) with rate division and timeout.

Parameters:
- DEV_ADDR, 8'h4D, accepted NEC address; frames with any other address are dropped.
- CH_MAX, 99, highest channel number; channels run 1..CH_MAX with wrap.
- VOL_MAX, 40, volume ceiling; volume range is 0..VOL_MAX, saturating.
- VOL_DEFAULT, 10, volume after reset.
- REPEAT_DIV, 2, apply one held-volume step every REPEAT_DIV accepted repeat pulses.
- HOLD_TIMEOUT, 6_000_000, sys_clk cycles (120 ms at 50 MHz) a repeat is honoured after the last frame/repeat.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous active-high reset.
- data  in  20  receiver data; [15:8] = address, [7:0] = command, [19:16] ignored.
- data_valid  in  1  receiver frame-valid (level or pulse); rising edge = new frame.
- repeat_en  in  1  receiver repeat indication; rising edge = one repeat.
- power_on  out  1  TV power state.
- channel  out  7  current channel, 1..CH_MAX.
- volume  out  6  current volume, 0..VOL_MAX.
- cmd_strobe  out  1  one-cycle pulse when an action is applied.
- cmd_id  out  3  action applied: 1 PWR, 2 CH_DN, 3 CH_UP, 4 VOL_DN, 5 VOL_UP; held while idle.
- unknown_cmd  out  1  one-cycle pulse: address matched, command not in table.

Behaviour:
- Reset (synchronous, sys_rst = 1 at a sys_clk edge), applied on that edge:
  - power_on = 0, channel = 1, volume = VOL_DEFAULT.
  - cmd_strobe = 0, cmd_id = 0, unknown_cmd = 0.
  - FSM = IDLE, edge-detect registers = 0, counters = 0.
- Edge detect: data_valid and repeat_en are registered once; an event is a 0→1 transition.
- Event latency: action registers and cmd_strobe update 2 cycles after the input rising edge (1 cycle edge detect + 1 cycle decode/update).
- Frame decode (data_valid event with data[15:8] == DEV_ADDR):
  - 8'h80 → PWR: toggle power_on.
  - 8'h38 → CH_DN.
  - 8'h18 → CH_UP.
  - 8'h08 → VOL_DN.
  - 8'h30 → VOL_UP.
  - Any other command → unknown_cmd pulse; no state change.
  - Address mismatch → silently ignored; no strobe, FSM unchanged.
- Power gating: while power_on = 0, all commands except PWR are ignored (no strobe, no state change).
- Channel arithmetic: CH_UP at CH_MAX → 1; CH_DN at 1 → CH_MAX; otherwise ±1.
- Volume arithmetic: VOL_UP saturates at VOL_MAX; VOL_DN saturates at 0.
  - cmd_strobe still pulses on a saturated request, with volume unchanged.
- FSM states:
  - IDLE: repeat events ignored. An accepted VOL_UP/VOL_DN frame → HOLD; latch the command, clear the timeout counter and repeat_cnt.
  - HOLD: timeout counter increments every cycle.
    - A repeat event clears the counter and increments repeat_cnt. When repeat_cnt reaches REPEAT_DIV, repeat_cnt resets to 0 and the latched volume action is applied (strobe + cmd_id).
    - Any accepted non-volume frame, or power_on falling → IDLE.
    - A new volume frame re-latches its command and stays in HOLD.
    - Counter reaching HOLD_TIMEOUT−1 → IDLE.
- PWR and channel commands never repeat (no auto-repeat on power toggle or channel).
- Simultaneous data_valid and repeat_en events in one cycle: the frame is processed and the repeat is discarded.
- Reset mid-HOLD: state returns to IDLE; a following repeat with no new frame is ignored.
- Only one action per cycle; cmd_strobe is never high for two consecutive cycles.

Test Plan:
1. Reset, then frame 0x4D/0x80 → power_on 0→1, cmd_strobe one cycle, cmd_id = 1. Then 0x4D/0x30 → volume 10→11, cmd_id = 5.
2. Power off (reset state), frame 0x4D/0x18 → no strobe, channel stays 1. Power on, then 0x4D/0x38 → channel = 99 (wrap). Then 0x4D/0x18 ×2 → channel = 2.
3. Power on, volume 40, frame 0x4D/0x30 → strobe, volume stays 40. Volume at 0, 0x4D/0x08 → volume stays 0.
4. Frame with address 0x12, command 0x80 → no strobe, power unchanged. Address 0x4D, command 0x55 → unknown_cmd pulse, no other output change.
5. HOLD_TIMEOUT = 1000, REPEAT_DIV = 2. VOL_UP frame, then 4 repeats 500 cycles apart → volume +1 (frame) +2 (repeats). A repeat 1200 cycles after the last one → ignored.
6. VOL_UP frame, then data_valid and repeat_en rising on the same cycle with CH_UP data → channel +1, FSM IDLE, next repeat ignored. sys_rst asserted during HOLD → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ir_cmd_ctrl.sv
// rtl/ir_cmd_ctrl.sv - NEC command decode, TV state registers and held-key repeat control
module ir_cmd_ctrl #(
  parameter logic [7:0]  DEV_ADDR     = 8'h4D,
  parameter int unsigned CH_MAX       = 99,
  parameter int unsigned VOL_MAX      = 40,
  parameter int unsigned VOL_DEFAULT  = 10,
  parameter int unsigned REPEAT_DIV   = 2,
  parameter int unsigned HOLD_TIMEOUT = 6_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic        data_valid,
  input  logic        repeat_en,
  output logic        power_on,
  output logic [6:0]  channel,
  output logic [5:0]  volume,
  output logic        cmd_strobe,
  output logic [2:0]  cmd_id,
  output logic        unknown_cmd
);

  localparam int CNT_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int RC_W  = $clog2(REPEAT_DIV + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REPEAT_DIV - 1);
  localparam logic [6:0]       CH_TOP   = 7'(CH_MAX);
  localparam logic [5:0]       VOL_TOP  = 6'(VOL_MAX);
  localparam logic [5:0]       VOL_RST  = 6'(VOL_DEFAULT);

  localparam logic [2:0] ACT_NONE   = 3'd0;
  localparam logic [2:0] ACT_PWR    = 3'd1;
  localparam logic [2:0] ACT_CH_DN  = 3'd2;
  localparam logic [2:0] ACT_CH_UP  = 3'd3;
  localparam logic [2:0] ACT_VOL_DN = 3'd4;
  localparam logic [2:0] ACT_VOL_UP = 3'd5;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [RC_W-1:0]  rep_cnt, rep_cnt_nxt;
  logic [2:0]       hold_act, hold_act_nxt;
  logic             frame_pend, frame_pend_nxt;
  logic             unknown_nxt;
  logic [2:0]       dec;
  logic [2:0]       act;

  logic        dv_d1, dv_d2, rp_d1, rp_d2;
  logic [15:0] data_q;
  logic        frame_ev, rep_ev;
  logic        unused_data_hi;

  assign unused_data_hi = ^data[19:16];

  // A frame held back one cycle (pending) keeps strobes from landing back to back.
  assign frame_ev = (dv_d1 & ~dv_d2) | frame_pend;
  assign rep_ev   = rp_d1 & ~rp_d2;

  // Register the receiver handshakes once for edge detection; capture the frame on its rising edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dv_d1  <= 1'b0;
      dv_d2  <= 1'b0;
      rp_d1  <= 1'b0;
      rp_d2  <= 1'b0;
      data_q <= '0;
    end else begin
      dv_d1 <= data_valid;
      dv_d2 <= dv_d1;
      rp_d1 <= repeat_en;
      rp_d2 <= rp_d1;
      if (data_valid && !dv_d1) begin
        data_q <= data[15:0];
      end
    end
  end

  // Decode frames and repeats into at most one action and the next hold-FSM state.
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    rep_cnt_nxt    = rep_cnt;
    hold_act_nxt   = hold_act;
    frame_pend_nxt = 1'b0;
    unknown_nxt    = 1'b0;
    dec            = ACT_NONE;
    act            = ACT_NONE;

    if (state == ST_HOLD) begin
      if (hold_cnt == CNT_LAST) begin
        state_nxt = ST_IDLE;
      end else begin
        hold_cnt_nxt = hold_cnt + 1'b1;
      end
    end

    if (frame_ev) begin
      if (cmd_strobe) begin
        frame_pend_nxt = 1'b1;
      end else if (data_q[15:8] == DEV_ADDR) begin
        case (data_q[7:0])
          8'h80:   dec = ACT_PWR;
          8'h38:   dec = ACT_CH_DN;
          8'h18:   dec = ACT_CH_UP;
          8'h08:   dec = ACT_VOL_DN;
          8'h30:   dec = ACT_VOL_UP;
          default: unknown_nxt = 1'b1;
        endcase
        // With the set off only the power key gets through.
        if (dec == ACT_PWR || (dec != ACT_NONE && power_on)) begin
          act = dec;
        end
        if (act == ACT_VOL_DN || act == ACT_VOL_UP) begin
          state_nxt    = ST_HOLD;
          hold_act_nxt = act;
          hold_cnt_nxt = '0;
          rep_cnt_nxt  = '0;
        end else if (act != ACT_NONE) begin
          state_nxt = ST_IDLE;
        end
      end
    end else if (state == ST_HOLD && rep_ev && !cmd_strobe) begin
      // A repeat wins over a timeout expiring in the same cycle.
      state_nxt    = ST_HOLD;
      hold_cnt_nxt = '0;
      if (rep_cnt == RC_LAST) begin
        rep_cnt_nxt = '0;
        act         = hold_act;
      end else begin
        rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end
  end

  // Hold-FSM state register and TV state/action registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      hold_act    <= ACT_NONE;
      frame_pend  <= 1'b0;
      power_on    <= 1'b0;
      channel     <= 7'd1;
      volume      <= VOL_RST;
      cmd_strobe  <= 1'b0;
      cmd_id      <= ACT_NONE;
      unknown_cmd <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      rep_cnt     <= rep_cnt_nxt;
      hold_act    <= hold_act_nxt;
      frame_pend  <= frame_pend_nxt;
      unknown_cmd <= unknown_nxt;
      cmd_strobe  <= (act != ACT_NONE);
      if (act != ACT_NONE) begin
        cmd_id <= act;
      end
      case (act)
        ACT_PWR:    power_on <= !power_on;
        ACT_CH_DN:  channel  <= (channel <= 7'd1) ? CH_TOP : channel - 7'd1;
        ACT_CH_UP:  channel  <= (channel >= CH_TOP) ? 7'd1 : channel + 7'd1;
        ACT_VOL_DN: if (volume != 6'd0) volume <= volume - 6'd1;
        ACT_VOL_UP: if (volume < VOL_TOP) volume <= volume + 6'd1;
        default: ;
      endcase
    end
  end

endmodule
